serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Receive side of the single-bit serial stream produced by our clocked pattern/sequence generators (one bit per `clck` edge on `out`).
- Hunts the incoming bit stream for a fixed sync word, then deserializes the following DATA_W bits (MSB first) into a parallel word.
- Pulses `data_valid` for each received word and keeps a wrap-around frame count.
- Sits directly downstream of a generator's serial output, for self-checking loopback in lab benches and on-board displays.

Parameters:
- SYNC_W, 4, sync word length in bits (>=2).
- SYNC_PAT, 4'b1101, sync pattern; first-received bit is the MSB.
- DATA_W, 8, payload bits per frame (>=1).
- CNT_W, 8, width of the frame counter.

Ports:
- clck  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  bit-valid qualifier; `in` is sampled only on edges where en=1.
- in  input  1  serial data bit.
- data  output  DATA_W  last received payload; first payload bit lands in the MSB.
- data_valid  output  1  one-cycle pulse when `data` is updated.
- locked  output  1  high while in LOAD, i.e. sync found and payload being collected.
- frame_cnt  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rstn=0, asynchronous, any time including mid-frame):
  - state=HUNT; sync history, fill counter, bit counter and shift register cleared.
  - data=0, data_valid=0, locked=0, frame_cnt=0.
- FSM states: HUNT, LOAD. `locked` is a registered decode of state==LOAD.
- HUNT, on each edge with en=1:
  - hist <= {hist[SYNC_W-2:0], in}; fill counter increments, saturating at SYNC_W.
  - Match when {hist[SYNC_W-2:0], in} == SYNC_PAT and at least SYNC_W bits have been sampled since entering HUNT (fill counter >= SYNC_W-1 before this bit). The fill qualifier prevents matches against cleared history.
  - Overlapping sync is allowed: the history is never cleared on a mismatch (e.g. 11101 matches on the 5th bit).
  - On match, next state is LOAD and bit_cnt=0; `locked` rises after this same edge.
- LOAD, on each edge with en=1:
  - shreg <= {shreg[DATA_W-2:0], in}; bit_cnt increments.
  - Bits inside the payload are never examined for sync.
  - On the edge sampling payload bit DATA_W-1:
    - data <= {shreg[DATA_W-2:0], in}
    - data_valid <= 1 for exactly one cycle
    - frame_cnt <= frame_cnt+1 (wraps from all-ones to 0)
    - state returns to HUNT; hist and fill counter cleared, so the next frame needs a full fresh sync word.
- en=0 edges: state, counters, hist and shreg hold. data_valid still drops after its single cycle. A gap of any length mid-sync or mid-payload is transparent.
- Latency: data_valid is high in the cycle immediately after the edge that sampled the last payload bit.
- `data` holds its value between frames; it is never cleared except by reset.
- Back-to-back frames: sync bits may start on the edge right after the last payload bit.
- No frame error detection: a lost bit simply yields a wrong word. Hunting resumes after DATA_W bits.

Test Plan:
1. Reset, en=1, stream 1,1,0,1 then 1,0,1,0,0,1,0,1 -> locked=1 from the edge after bit 4; data=8'hA5 and data_valid=1 for one cycle after bit 12; frame_cnt=1; locked=0.
2. Overlapping sync 1,1,1,0,1 then payload 0x3C -> match on the 5th bit; data=8'h3C, frame_cnt=1.
3. Same frame as scenario 1 with en=0 for 3 cycles after payload bit 2 and for 1 cycle after sync bit 3 -> data=8'hA5, with exactly one data_valid pulse.
4. Two back-to-back frames with payloads 0xD0 (contains 1101) and 0x0D -> no false sync inside the payloads; data=8'hD0 then 8'h0D; two pulses; frame_cnt=2.
5. Assert rstn low for 1 cycle after payload bit 5 of a frame -> data=0, locked=0, frame_cnt=0 immediately (asynchronous); the next complete frame with payload 0x5A gives data=8'h5A, frame_cnt=1.
6. Send 257 frames with payload = frame index -> frame_cnt wraps to 0 after frame 256 and reads 1 after frame 257; the last data=8'h00 (index 256 truncated to 8 bits).

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a serial bit stream for a sync word, then deserializes the
// following DATA_W bits (MSB first) into a parallel word with a valid pulse and frame count.
module serial_frame_rx #(
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
  parameter int                DATA_W   = 8,
  parameter int                CNT_W    = 8
) (
  input  logic              clck,
  input  logic              rstn,
  input  logic              en,
  input  logic              in,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              locked,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int FW = $clog2(SYNC_W + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int SW = (DATA_W > 1) ? DATA_W - 1 : 1;
  typedef enum logic {HUNT, LOAD} state_t;
  state_t              state_q, state_d;
  logic [SYNC_W-2:0]   hist_q, hist_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [SW-1:0]       shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                locked_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SYNC_W-1:0]   win;
  logic [DATA_W-1:0]   word;
  assign win  = {hist_q, in};
  assign word = DATA_W'({shreg_q, in});
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (en && state_q == HUNT) begin
      hist_d = win[SYNC_W-2:0];
      fill_d = (fill_q == FW'(SYNC_W)) ? fill_q : fill_q + 1'b1;
      // fill qualifier keeps cleared history from faking a match
      if (fill_q >= FW'(SYNC_W - 1) && win == SYNC_PAT) begin
        state_d = LOAD;
        bit_d   = '0;
      end
    end else if (en) begin
      shreg_d = SW'(word);
      bit_d   = bit_q + 1'b1;
      if (bit_q == BW'(DATA_W - 1)) begin
        data_d  = word;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = HUNT;
        hist_d  = '0;
        fill_d  = '0;
        bit_d   = '0;
      end
    end
  end
  always_ff @(posedge clck or negedge rstn) begin
    if (!rstn) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      locked_q <= (state_d == LOAD);
      cnt_q    <= cnt_d;
    end
  end
  assign data       = data_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed scenarios plus randomized stream checked against a
// bit-level behavioural model of sync hunting and payload capture.
module tb_serial_frame_rx;
  logic       clck = 1'b0;
  logic       rstn = 1'b0;
  logic       en   = 1'b0;
  logic       in   = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       locked;
  logic [7:0] frame_cnt;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  // behavioural model state
  bit      m_load;
  int      m_seen, m_hist, m_nb, m_word, m_data, m_cnt;
  bit      m_valid;
  serial_frame_rx dut (
    .clck(clck), .rstn(rstn), .en(en), .in(in),
    .data(data), .data_valid(data_valid), .locked(locked), .frame_cnt(frame_cnt)
  );
  always #5 clck = ~clck;
  task automatic model_reset();
    m_load = 0; m_seen = 0; m_hist = 0; m_nb = 0; m_word = 0;
    m_data = 0; m_cnt = 0; m_valid = 0;
  endtask
  task automatic model_bit(input bit b);
    m_valid = 0;
    if (!m_load) begin
      m_hist = (m_hist * 2 + b) % 16;
      m_seen++;
      if (m_seen >= 4 && m_hist == 13) begin
        m_load = 1; m_nb = 0; m_word = 0;
      end
    end else begin
      m_word = (m_word * 2 + b) % 256;
      m_nb++;
      if (m_nb == 8) begin
        m_data = m_word; m_valid = 1; m_cnt = (m_cnt + 1) % 256;
        m_load = 0; m_seen = 0; m_hist = 0;
      end
    end
  endtask
  task automatic step(input logic e, input logic b);
    @(negedge clck);
    en = e; in = b;
    @(posedge clck);
    if (rstn) begin
      if (e) model_bit(b);
      else m_valid = 0;
    end
    #1;
    if (data_valid) pulses++;
  endtask
  task automatic send_frame(input logic [7:0] p, input int gap_sync3, input int gap_pay2);
    logic [3:0] s;
    s = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, s[i]);
      if (i == 1) for (int g = 0; g < gap_sync3; g++) step(1'b0, 1'b0);
    end
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, p[i]);
      if (i == 6) for (int g = 0; g < gap_pay2; g++) step(1'b0, 1'b0);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clck);
    rstn = 1'b0;
    model_reset();
    @(negedge clck);
    rstn = 1'b1;
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clck);
    #1;
    checks++;
    if (data !== 8'h00 || data_valid !== 1'b0 || locked !== 1'b0 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset: data=%h valid=%b locked=%b cnt=%h, required 00 0 0 00", data, data_valid, locked, frame_cnt);
    end
    @(negedge clck);
    rstn = 1'b1;
  endtask
  task automatic test_basic();
    logic [3:0] s;
    logic [7:0] p;
    s = 4'b1101; p = 8'hA5; pulses = 0;
    for (int i = 3; i >= 1; i--) step(1'b1, s[i]);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL basic_prelock: locked=%b required 0", locked); end
    step(1'b1, s[0]);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL basic_lock: locked=%b required 1", locked); end
    for (int i = 7; i >= 0; i--) step(1'b1, p[i]);
    checks++;
    if (data !== 8'hA5 || data_valid !== 1'b1 || frame_cnt !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame: data=%h valid=%b cnt=%0d locked=%b, required a5 1 1 0", data, data_valid, frame_cnt, locked);
    end
    step(1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_pulse_end: valid=%b data=%h, required 0 a5", data_valid, data);
    end
  endtask
  task automatic test_overlap();
    logic [4:0] s;
    logic [7:0] p;
    s = 5'b11101; p = 8'h3C;
    pulse_reset();
    for (int i = 4; i >= 1; i--) step(1'b1, s[i]);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL overlap_4th: locked=%b required 0", locked); end
    step(1'b1, s[0]);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL overlap_5th: locked=%b required 1", locked); end
    for (int i = 7; i >= 0; i--) step(1'b1, p[i]);
    checks++;
    if (data !== 8'h3C || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overlap_frame: data=%h cnt=%0d, required 3c 1", data, frame_cnt);
    end
  endtask
  task automatic test_gaps();
    pulse_reset();
    pulses = 0;
    send_frame(8'hA5, 1, 3);
    repeat (2) step(1'b0, 1'b0);
    checks++;
    if (data !== 8'hA5 || pulses !== 1 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL gaps: data=%h pulses=%0d cnt=%0d, required a5 1 1", data, pulses, frame_cnt);
    end
  endtask
  task automatic test_back_to_back();
    pulse_reset();
    pulses = 0;
    send_frame(8'hD0, 0, 0);
    checks++;
    if (data !== 8'hD0 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: data=%h valid=%b, required d0 1", data, data_valid);
    end
    send_frame(8'h0D, 0, 0);
    checks++;
    if (data !== 8'h0D || frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL b2b_second: data=%h cnt=%0d, required 0d 2", data, frame_cnt);
    end
    step(1'b0, 1'b0);
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: pulses=%0d required 2", pulses); end
  endtask
  task automatic test_async_reset();
    logic [3:0] s;
    logic [7:0] p;
    s = 4'b1101; p = 8'hFF;
    pulse_reset();
    send_frame(8'h77, 0, 0);
    for (int i = 3; i >= 0; i--) step(1'b1, s[i]);
    for (int i = 7; i >= 3; i--) step(1'b1, p[i]);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (data !== 8'h00 || locked !== 1'b0 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: data=%h locked=%b cnt=%0d, required 00 0 0", data, locked, frame_cnt);
    end
    @(posedge clck);
    @(negedge clck);
    rstn = 1'b1;
    send_frame(8'h5A, 0, 0);
    checks++;
    if (data !== 8'h5A || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL async_reset_next: data=%h cnt=%0d, required 5a 1", data, frame_cnt);
    end
  endtask
  task automatic test_wrap();
    pulse_reset();
    for (int i = 0; i < 257; i++) begin
      send_frame(8'(i), 0, 0);
      if (i == 255) begin
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_256: cnt=%0d required 0", frame_cnt); end
      end
    end
    checks++;
    if (frame_cnt !== 8'd1 || data !== 8'h00) begin
      errors++;
      $display("FAIL wrap_257: cnt=%0d data=%h, required 1 00", frame_cnt, data);
    end
  endtask
  task automatic test_random();
    logic e, b;
    pulse_reset();
    for (int c = 0; c < 2000; c++) begin
      e = ($urandom_range(0, 9) < 8);
      b = ($urandom_range(0, 9) < 6);
      step(e, b);
      checks++;
      if (data !== 8'(m_data) || data_valid !== m_valid || locked !== m_load || frame_cnt !== 8'(m_cnt)) begin
        errors++;
        $display("FAIL random c=%0d: data=%h valid=%b locked=%b cnt=%0d, required %h %b %b %0d",
                 c, data, data_valid, locked, frame_cnt, m_data[7:0], m_valid, m_load, m_cnt);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
